mem_unit: RTL
=============

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: MEM_clk  input  1  rising-edge clock; MEM_rst_n  input  1  asynchronous reset, active low.
REQ-002 MAR_we  input  1  load MAR this edge.
REQ-003 MAR_mux  input  1  MAR source: 0 = PC_out, 1 = {4'h0, IR_addr}.
REQ-004 MBR_we  input  1  load MBR this edge.
REQ-005 MBR_mux  input  1  MBR source: 0 = RAM[MAR_out], 1 = RF_data.
REQ-006 RAM_we  input  1  write MBR_out into RAM[MAR_out] this edge.
REQ-007 PC_inc  input  1  increment PC this edge.
REQ-008 IR_addr  input  4  operand address field from the instruction.
REQ-009 RF_data  input  8  register-file data for stores.
REQ-010 boot_done  input  1  single-cycle pulse ending program load.
REQ-011 load_valid / load_addr / load_data  input  1/8/8  program-load write request, address, byte.
REQ-012 load_ready  output  1  high while in BOOT.
REQ-013 MEM_run  output  1  high while in RUN.
REQ-014 PC_out / MAR_out / MBR_out  output  8 each  register contents.
REQ-015 bus_err  output  1  sticky protocol-violation flag.

Function
REQ-016 All registers SHALL update only on the rising MEM_clk edge, except under asynchronous reset.
REQ-017 FSM states: BOOT, RUN. BOOT -> RUN when boot_done=1. RUN is terminal until reset. boot_done in RUN has no effect.
REQ-018 load_ready SHALL equal (state==BOOT) and MEM_run SHALL equal (state==RUN), both decoded combinationally from state.
REQ-019 BOOT: on each edge with load_valid=1, RAM[load_addr] <= load_data. MAR_we, MBR_we, RAM_we and PC_inc are ignored.
REQ-020 BOOT with load_valid=1 and boot_done=1 on the same edge: the byte is written and the state moves to RUN.
REQ-021 RUN: PC <= PC+1 mod 256 when PC_inc=1; 8'hFF wraps to 8'h00.
REQ-022 RUN: MAR <= MAR_mux ? {4'h0, IR_addr} : PC_out when MAR_we=1. The pre-edge PC is used when PC_inc is asserted on the same edge.
REQ-023 RUN: MBR <= MBR_mux ? RF_data : RAM[MAR_out] when MBR_we=1. The pre-edge MAR is used when MAR_we is asserted on the same edge.
REQ-024 RUN: RAM[MAR_out] <= MBR_out when RAM_we=1, using pre-edge MAR and MBR values.
REQ-025 RAM: 256x8, asynchronous read, synchronous write, contents not reset.
REQ-026 RUN, RAM_we=1 and MBR_we=1 on the same edge: the RAM write uses the old MBR, MBR loads normally, and bus_err <= 1.
REQ-027 RUN with load_valid=1: the request is ignored (no RAM write) and bus_err <= 1.
REQ-028 bus_err SHALL remain set until reset.
REQ-029 Read-after-write on the next edge with the same MAR SHALL return the newly written byte.

Reset
REQ-030 While MEM_rst_n=0, the block SHALL hold PC_out=0, MAR_out=0, MBR_out=0, bus_err=0, state=BOOT, load_ready=1, MEM_run=0.
REQ-031 Reset asserted mid-operation SHALL abort any write on that edge. RAM contents already written SHALL be preserved.
REQ-032 Release SHALL be synchronous-safe: the first edge after deassertion SHALL behave as a normal BOOT edge.

Verification
REQ-033 Reset, then load_valid with (addr,data) = (00,0A), (01,35), (0F,77), then boot_done -> RAM[00]=0A, RAM[01]=35, RAM[0F]=77; MEM_run=1, load_ready=0.
REQ-034 Fetch sequence MAR_we(mux0); MBR_we(mux0)+PC_inc; with RAM[00]=0A -> MAR_out=00, MBR_out=0A, PC_out=01.
REQ-035 Store: MAR_we mux1 with IR_addr=F; MBR_we mux1 with RF_data=5C; RAM_we; then MBR_we mux0 -> RAM[0F]=5C, MBR_out=5C.
REQ-036 PC_inc held for 256 edges from 00 -> PC_out=00 again; 255 edges -> FF.
REQ-037 RUN with RAM_we and MBR_we together (MBR=11, RF_data=22, mux1) -> RAM[MAR]=11, MBR_out=22, bus_err=1. Stray load_valid in RUN -> no write, bus_err stays 1.
REQ-038 MEM_rst_n pulsed low in RUN with PC=07 -> PC=00, bus_err=0, state BOOT; RAM contents unchanged.

Source files
------------

// File: rtl/mem_unit.sv
// Memory unit: PC, MAR and MBR around a 256x8 RAM. A BOOT phase accepts
// program-load writes, and a RUN phase executes the fetch and store micro-operations.
module mem_unit (
  input  logic       MEM_clk,
  input  logic       MEM_rst_n,
  input  logic       MAR_we,
  input  logic       MAR_mux,
  input  logic       MBR_we,
  input  logic       MBR_mux,
  input  logic       RAM_we,
  input  logic       PC_inc,
  input  logic [3:0] IR_addr,
  input  logic [7:0] RF_data,
  input  logic       boot_done,
  input  logic       load_valid,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       MEM_run,
  output logic [7:0] PC_out,
  output logic [7:0] MAR_out,
  output logic [7:0] MBR_out,
  output logic       bus_err
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t     state, next_state;
  logic [7:0] ram [0:255];
  logic [7:0] pc_q, mar_q, mbr_q;
  logic       bus_err_q;
  logic       ram_wr;
  logic [7:0] ram_wa, ram_wd, ram_rd;

  always_ff @(posedge MEM_clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) state <= BOOT;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == BOOT && boot_done) next_state = RUN;
  end

  assign load_ready = (state == BOOT);
  assign MEM_run    = (state == RUN);

  assign ram_rd = ram[mar_q];

  // A single write port serves both the boot loader and RUN-phase stores.
  // It is gated by reset so that a reset held across an edge aborts any write.
  always_comb begin
    ram_wr = 1'b0;
    ram_wa = mar_q;
    ram_wd = mbr_q;
    if (state == BOOT) begin
      ram_wr = load_valid;
      ram_wa = load_addr;
      ram_wd = load_data;
    end else begin
      ram_wr = RAM_we;
    end
    if (!MEM_rst_n) ram_wr = 1'b0;
  end

  always_ff @(posedge MEM_clk) begin
    if (ram_wr) ram[ram_wa] <= ram_wd;
  end

  always_ff @(posedge MEM_clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) begin
      pc_q      <= 8'h00;
      mar_q     <= 8'h00;
      mbr_q     <= 8'h00;
      bus_err_q <= 1'b0;
    end else if (state == RUN) begin
      if (PC_inc) pc_q <= pc_q + 8'h01;
      if (MAR_we) mar_q <= MAR_mux ? {4'h0, IR_addr} : pc_q;
      if (MBR_we) mbr_q <= MBR_mux ? RF_data : ram_rd;
      // Simultaneous store and MBR load, or a load request after boot, are protocol errors.
      if ((RAM_we && MBR_we) || load_valid) bus_err_q <= 1'b1;
    end
  end

  assign PC_out  = pc_q;
  assign MAR_out = mar_q;
  assign MBR_out = mbr_q;
  assign bus_err = bus_err_q;

endmodule
